// File: rtl/reaction_game_core.sv
// Multi-round reaction-time game controller: countdown, random wait, cue, timed hit, scoring.
// Optional REACTION_GAME_RETRY_EN: early hits in WAIT restart the round's countdown (max 3 per round).
module reaction_game_core #(
  parameter int ROUNDS        = 3,
  parameter int TICK_DIV      = 1_000_000,
  parameter int TIMEOUT_TICKS = 300,
  parameter int MIN_DELAY     = 100,
  parameter int COUNT_S       = 5,
  parameter int RESULT_TICKS  = 200,
  parameter int CNT_W         = 9
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_start,
  input  logic             i_hit,
  input  logic [CNT_W-1:0] i_seed,
  output logic [2:0]       o_state,
  output logic [2:0]       o_countdown,
  output logic             o_cue_active,
  output logic [3:0]       o_round_idx,
  output logic [1:0]       o_result_code,
  output logic [CNT_W-1:0] o_last_score,
  output logic [CNT_W-1:0] o_best_score,
  output logic [CNT_W+3:0] o_total_score,
  output logic             o_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_COUNTDOWN = 3'd1, S_WAIT = 3'd2,
    S_CUE  = 3'd3, S_RESULT    = 3'd4, S_DONE = 3'd5
  } state_t;

  localparam int               PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_DELAY);
  localparam logic [CNT_W-1:0] RESULT_C   = CNT_W'(RESULT_TICKS);
  localparam logic [2:0]       COUNT_C    = 3'(COUNT_S);
  localparam logic [3:0]       LAST_ROUND = 4'(ROUNDS - 1);
  localparam logic [1:0]       RC_NONE = 2'd0, RC_OK = 2'd1, RC_EARLY = 2'd2, RC_TIMEOUT = 2'd3;

  state_t             r_state, w_next;
  logic [PW-1:0]      r_presc;
  logic               r_hit_q;
  logic [8:0]         r_lfsr;
  logic [CNT_W-1:0]   r_free;
  logic [6:0]         r_sec_ticks;
  logic [2:0]         r_countdown;
  logic [CNT_W-1:0]   r_timer;
  logic [3:0]         r_round;
  logic [1:0]         r_code;
  logic [CNT_W-1:0]   r_last, r_best;
  logic [CNT_W+3:0]   r_total;
`ifdef REACTION_GAME_RETRY_EN
  logic [1:0]         r_retry;
`endif

  logic               w_tick, w_hit_rise, w_start_ok, w_entry;
  logic               w_score_en, w_retry;
  logic [1:0]         w_code;
  logic [CNT_W-1:0]   w_score, w_lfsr_ext, w_delay, w_seed_mix;
  logic [8:0]         w_lfsr_load;
  logic [CNT_W+4:0]   w_sum;

  assign w_tick      = (r_presc == TICK_LAST);
  assign w_hit_rise  = i_hit & ~r_hit_q;
  assign w_start_ok  = i_enable & i_start & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_entry     = (w_next != r_state);
  assign w_seed_mix  = i_seed ^ r_free;
  assign w_lfsr_load = (9'(w_seed_mix) == 9'd0) ? 9'h1FF : 9'(w_seed_mix);
  assign w_lfsr_ext  = CNT_W'(r_lfsr);
  assign w_delay     = (w_lfsr_ext < MIN_C) ? w_lfsr_ext + MIN_C : w_lfsr_ext;
  assign w_sum       = (CNT_W+5)'(r_total) + (CNT_W+5)'(w_score);

  always_comb begin
    w_next     = r_state;
    w_score    = '0;
    w_code     = RC_NONE;
    w_score_en = 1'b0;
    w_retry    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: if (i_start) w_next = S_COUNTDOWN;
      S_COUNTDOWN:    if (r_countdown == COUNT_C) w_next = S_WAIT;
      S_WAIT: begin
`ifdef REACTION_GAME_RETRY_EN
        w_retry = w_hit_rise && (r_retry != 2'd3);
`endif
        if (w_retry) begin
          w_next = S_COUNTDOWN;
        end else if (w_hit_rise) begin
          w_next = S_RESULT; w_score_en = 1'b1; w_code = RC_EARLY; w_score = TIMEOUT_C;
        end else if (r_timer == '0) begin
          w_next = S_CUE;
        end
      end
      S_CUE: begin
        // A hit on the timeout cycle still counts as a valid reaction.
        if (w_hit_rise) begin
          w_next = S_RESULT; w_score_en = 1'b1; w_code = RC_OK; w_score = r_timer;
        end else if (r_timer == TIMEOUT_C) begin
          w_next = S_RESULT; w_score_en = 1'b1; w_code = RC_TIMEOUT; w_score = TIMEOUT_C;
        end
      end
      S_RESULT: if (r_timer == RESULT_C) w_next = (r_round == LAST_ROUND) ? S_DONE : S_COUNTDOWN;
      default:  w_next = S_IDLE;
    endcase
    if (!i_enable) begin
      w_next     = S_IDLE;
      w_score_en = 1'b0;
      w_retry    = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_hit_q     <= 1'b0;
      r_lfsr      <= 9'h1FF;
      r_free      <= '0;
      r_sec_ticks <= '0;
      r_countdown <= '0;
      r_timer     <= '0;
      r_round     <= '0;
      r_code      <= RC_NONE;
      r_last      <= '0;
      r_best      <= '1;
      r_total     <= '0;
`ifdef REACTION_GAME_RETRY_EN
      r_retry     <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_hit_q <= i_hit;
      r_free  <= r_free + 1'b1;
      r_lfsr  <= w_start_ok ? w_lfsr_load : {r_lfsr[7:0], r_lfsr[8] ^ r_lfsr[4]};
      r_presc <= (w_entry || w_tick) ? '0 : r_presc + 1'b1;

      // r_timer is the WAIT delay, the CUE elapsed count and the RESULT hold count.
      if (w_tick) begin
        case (r_state)
          S_COUNTDOWN: begin
            if (r_sec_ticks == 7'd99) begin
              r_sec_ticks <= '0;
              r_countdown <= r_countdown + 1'b1;
            end else begin
              r_sec_ticks <= r_sec_ticks + 1'b1;
            end
          end
          S_WAIT:          if (r_timer != '0) r_timer <= r_timer - 1'b1;
          S_CUE, S_RESULT: r_timer <= r_timer + 1'b1;
          default: ;
        endcase
      end

      if (w_entry) begin
        case (w_next)
          S_COUNTDOWN: begin
            r_sec_ticks <= '0;
            r_countdown <= '0;
          end
          S_WAIT:          r_timer <= w_delay;
          S_CUE, S_RESULT: r_timer <= '0;
          default: ;
        endcase
      end

      if (w_score_en) begin
        r_last  <= w_score;
        r_code  <= w_code;
        r_total <= w_sum[CNT_W+4] ? '1 : w_sum[CNT_W+3:0];
        if (w_code == RC_OK && w_score < r_best) r_best <= w_score;
      end

      if (r_state == S_RESULT && w_next == S_COUNTDOWN) begin
        r_round <= r_round + 1'b1;
`ifdef REACTION_GAME_RETRY_EN
        r_retry <= '0;
`endif
      end

`ifdef REACTION_GAME_RETRY_EN
      if (w_retry) begin
        r_retry <= r_retry + 1'b1;
        r_code  <= RC_EARLY;
      end
`endif

      if (w_start_ok) begin
        r_round <= '0;
        r_total <= '0;
        r_code  <= RC_NONE;
        r_best  <= '1;
`ifdef REACTION_GAME_RETRY_EN
        r_retry <= '0;
`endif
      end
    end
  end

  assign o_state       = r_state;
  assign o_countdown   = r_countdown;
  assign o_cue_active  = (r_state == S_CUE);
  assign o_round_idx   = r_round;
  assign o_result_code = r_code;
  assign o_last_score  = r_last;
  assign o_best_score  = r_best;
  assign o_total_score = r_total;
  assign o_done        = (r_state == S_DONE);

endmodule

// File: tb/tb_reaction_game_core.sv
// Randomized bench for reaction_game_core; expectations come from a tick-level game model.
module tb_reaction_game_core;
  localparam int TD = 4, TO = 20, MD = 5, CS = 1, RT = 3, NR = 2, CW = 9;
  localparam int MODE_HIT = 0, MODE_EARLY = 1, MODE_NONE = 2;
  localparam int ST_IDLE = 0, ST_CD = 1, ST_WAIT = 2, ST_CUE = 3, ST_RES = 4, ST_DONE = 5;
  localparam int ALL1 = (1 << CW) - 1;
  localparam int TOT_MAX = (1 << (CW + 4)) - 1;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, start = 1'b0, hit = 1'b0;
  logic [CW-1:0]   seed = '0;
  logic [2:0]      state, countdown;
  logic            cue_active, done;
  logic [3:0]      round_idx;
  logic [1:0]      result_code;
  logic [CW-1:0]   last_score, best_score;
  logic [CW+3:0]   total_score;

  reaction_game_core #(
    .ROUNDS(NR), .TICK_DIV(TD), .TIMEOUT_TICKS(TO), .MIN_DELAY(MD),
    .COUNT_S(CS), .RESULT_TICKS(RT), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_start(start), .i_hit(hit),
    .i_seed(seed), .o_state(state), .o_countdown(countdown), .o_cue_active(cue_active),
    .o_round_idx(round_idx), .o_result_code(result_code), .o_last_score(last_score),
    .o_best_score(best_score), .o_total_score(total_score), .o_done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int m_total, m_best, m_last, m_code;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Counts negedges until the state is reached; expiry is reported as a failure.
  task automatic wait_state(input int target, input int budget, output int n);
    n = 0;
    while (int'(state) != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (int'(state) != target) chk("wait_state", int'(state), target);
  endtask

  task automatic record(input int code, input int score);
    m_last = score;
    m_code = code;
    m_total = (m_total + score > TOT_MAX) ? TOT_MAX : m_total + score;
    if (code == 1 && score < m_best) m_best = score;
  endtask

  task automatic check_scores();
    chk("last_score",  int'(last_score),  m_last);
    chk("result_code", int'(result_code), m_code);
    chk("total_score", int'(total_score), m_total);
    chk("best_score",  int'(best_score),  m_best);
  endtask

  task automatic start_game();
    seed  = CW'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_total = 0; m_best = ALL1; m_code = 0;
    chk("start_state", int'(state), ST_CD);
    chk("start_round", int'(round_idx), 0);
    check_scores();
  endtask

  task automatic early_hit(input int d);
    repeat (d) @(negedge clk);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
  endtask

  // Entered on the first negedge of COUNTDOWN for round rnd.
  task automatic play_round(input int mode, input int d, input int rnd);
    int n;
`ifdef REACTION_GAME_RETRY_EN
    if (mode == MODE_EARLY) begin
      for (int r = 0; r < 3; r++) begin
        wait_state(ST_WAIT, 1000, n);
        chk("cd_cycles", n, CS * 100 * TD + 1);
        early_hit(d);
        m_code = 2;
        chk("retry_state", int'(state), ST_CD);
        chk("retry_round", int'(round_idx), rnd);
        check_scores();
      end
    end
`endif
    wait_state(ST_WAIT, 1000, n);
    chk("cd_cycles", n, CS * 100 * TD + 1);
    if (mode == MODE_EARLY) begin
      early_hit(d);
      record(2, TO);
    end else begin
      wait_state(ST_CUE, 3000, n);
      chk("wait_min",  int'(n >= MD * TD + 1), 1);
      chk("wait_max",  int'(n <= 511 * TD + 1), 1);
      chk("wait_grid", (n - 1) % TD, 0);
      chk("cue_active", int'(cue_active), 1);
      if (mode == MODE_HIT && d <= TO * TD) begin
        early_hit(d);
        record(1, d / TD);
      end else begin
        n = 0;
        while (int'(state) == ST_CUE && n < TO * TD + 10) begin
          @(negedge clk);
          n++;
        end
        chk("timeout_cycles", n, TO * TD + 1);
        record(3, TO);
      end
    end
    chk("result_state", int'(state), ST_RES);
    check_scores();
    n = 0;
    while (int'(state) == ST_RES && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_cycles", n, RT * TD + 1);
    chk("after_result", int'(state), (rnd == NR - 1) ? ST_DONE : ST_CD);
    chk("round_next", int'(round_idx), (rnd == NR - 1) ? rnd : rnd + 1);
    chk("done", int'(done), int'(rnd == NR - 1));
  endtask

  initial begin
    int n, mode, d;
    rst_n = 1'b0; enable = 1'b1;
    repeat (3) @(negedge clk);
    m_last = 0; m_code = 0; m_total = 0; m_best = ALL1;
    chk("rst_state", int'(state), ST_IDLE);
    chk("rst_round", int'(round_idx), 0);
    chk("rst_done", int'(done), 0);
    check_scores();
    rst_n = 1'b1;
    @(negedge clk);

    start_game();
    play_round(MODE_HIT, 28, 0);
    play_round(MODE_HIT, 31, 1);
    chk("gameA_total", int'(total_score), 14);

    start_game();
    play_round(MODE_EARLY, 5, 0);
    play_round(MODE_HIT, $urandom_range(0, TO * TD), 1);

    start_game();
    play_round(MODE_NONE, 0, 0);
    play_round(MODE_HIT, TO * TD, 1);

    for (int g = 0; g < 3; g++) begin
      start_game();
      for (int r = 0; r < NR; r++) begin
        mode = $urandom_range(0, 2);
        d = (mode == MODE_EARLY) ? $urandom_range(0, 15) : $urandom_range(0, TO * TD + 4);
        play_round(mode, d, r);
      end
    end

    start_game();
    play_round(MODE_HIT, 12, 0);
    wait_state(ST_WAIT, 1000, n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ignored", int'(state), ST_WAIT);
    enable = 1'b0;
    @(negedge clk);
    chk("disable_state", int'(state), ST_IDLE);
    chk("disable_round", int'(round_idx), 1);
    check_scores();
    enable = 1'b1;
    @(negedge clk);
    chk("idle_hold", int'(state), ST_IDLE);
    start_game();

    wait_state(ST_CUE, 3000, n);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_state", int'(state), ST_IDLE);
    chk("midrst_best", int'(best_score), ALL1);
    chk("midrst_round", int'(round_idx), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_cue", int'(cue_active), 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
